uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive end of the 8N1 serial link whose transmit side drives `uart_txd` from the SoC. It samples the asynchronous `uart_rxd` line, deserialises frames at a fixed divisor, and queues received bytes in a first-word-fall-through FIFO. A valid/ready stream port lets the core or a debug bridge drain the bytes. It sits on the PLL output clock, next to the core, inside the FPGA top level.

## Interface
- `DIV`, 868: `sys_clock` cycles per bit; legal range 16..65535. 868 gives 115200 baud at 100 MHz.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `sys_clock` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `uart_rxd` in 1: serial input, asynchronous, idles high.
- `rx_data` out 8: head-of-FIFO byte; valid only while `rx_valid`=1.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts the head when `rx_valid`&`rx_ready`.
- `rx_level` out clog2(DEPTH)+1: current FIFO occupancy.
- `frame_err` out 1: one-cycle pulse when a stop bit samples 0.
- `overflow` out 1: sticky; set when a good byte is dropped because the FIFO is full.
- `overflow_clr` in 1: synchronous clear of `overflow`.

## Operation
- Input path: 2-flop synchroniser; both flops reset to 1. The FSM sees only the synchronised `rxd_s`.
- Bit counter: width clog2(DIV). Bit index: 3 bits. Shift register: 8 bits, LSB received first.
- FSM state IDLE:
  - `rxd_s`=0 → START, counter=0.
- FSM state START:
  - When counter reaches DIV/2−1 (integer division), sample `rxd_s`.
  - Sample 1 → false start; return to IDLE with no error.
  - Sample 0 → go to DATA with counter=0 and bit index=0.
- FSM state DATA:
  - When counter reaches DIV−1, sample `rxd_s` into the shift register MSB, shifting right, and reset the counter.
  - After bit index 7 is sampled → STOP.
- FSM state STOP:
  - At counter DIV−1, sample `rxd_s`.
  - Sample 1 → push the byte into the FIFO.
  - Sample 0 → pulse `frame_err` and discard the byte.
  - Either outcome → IDLE.
- Continuous break (line held low) produces back-to-back frames of 0x00 with `frame_err` pulses; this is the required behaviour.
- FIFO:
  - Circular buffer with read/write pointers of clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - `rx_data` is driven from the entry at the read pointer.
  - Pop occurs when `rx_valid`&`rx_ready`.
- FIFO full plus push:
  - Without a pop in the same cycle, the byte is dropped and `overflow` is set.
  - With a pop in the same cycle, the push is accepted, the level is unchanged, and `overflow` is not set.
- `overflow_clr` in the same cycle as a new overflow: set wins.
- Empty FIFO: no bypass. `rx_ready` with `rx_valid`=0 has no effect.

## Timing
- Reset values:
  - FSM = IDLE; counters = 0; pointers = 0.
  - `rx_valid`=0, `rx_level`=0, `rx_data`=0 (storage is not reset; the output mux is gated to 0 when empty).
  - `frame_err`=0, `overflow`=0; synchroniser = 1.
- Reset asserted mid-frame aborts the frame immediately and empties the FIFO. After release, the block waits for the next falling edge on `rxd_s`.
- Latency:
  - A falling edge on `uart_rxd` is seen in IDLE 2 cycles later.
  - The push happens in the stop-sample cycle, DIV/2 + 9·DIV cycles after IDLE exits.
  - `rx_valid` and `rx_level` update on the following clock edge.
- `frame_err` is asserted for exactly the cycle after the stop sample.
- `rx_level` counts +1 per push and −1 per pop; a simultaneous push and pop leaves it unchanged.
- Throughput: the next start bit is accepted from the cycle after the stop sample, so back-to-back frames (10 bits) are received with no loss.

## Test plan
- Single byte test:
  - Stimulus: DIV=16; drive 0xA5 in 8N1 with `rx_ready`=0.
  - Required: `rx_valid` rises 2+8+144+1 cycles after the start edge; `rx_data`=0xA5; `rx_level`=1; no `frame_err`.
- Glitch test:
  - Stimulus: low pulse of 4 cycles on idle line.
  - Required: START rejects it; FIFO stays empty; no `frame_err`.
- Bad stop bit test:
  - Stimulus: 0x3C with stop bit driven 0.
  - Required: one-cycle `frame_err`; `rx_level` stays 0. A following good 0x81 is received correctly.
- Overflow test:
  - Stimulus: DEPTH=4; send 0x01..0x05 back-to-back with `rx_ready`=0.
  - Required: `rx_level`=4 and `overflow`=1; the FIFO drains 0x01..0x04. `overflow_clr` clears the flag.
- Full with simultaneous pop test:
  - Stimulus: FIFO full; hold `rx_ready`=1 only in the stop-sample cycle of 0x77.
  - Required: 0x77 is stored; level stays 4; `overflow`=0.
- Mid-frame reset test:
  - Stimulus: pulse `reset_n` low during DATA bit 3 with 2 bytes queued.
  - Required: all outputs return to reset values; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a fixed bit divisor, feeding a first-word-fall-through
// byte FIFO that is drained through a valid/ready stream port.

module uart_rx_fifo #(
    parameter int DIV   = 868,
    parameter int DEPTH = 16
) (
    input  logic                   sys_clock,
    input  logic                   reset_n,
    input  logic                   uart_rxd,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   overflow_clr
);
    localparam int CW = $clog2(DIV);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, rxd_s_q;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push, pop, full, push_ok, ovf_set;

    // Both synchroniser flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            rxd_s_q <= sync1_q;
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    push        = rxd_s_q;
                    frame_err_d = ~rxd_s_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        pop        = rx_valid & rx_ready;
        full       = (rx_level == LVL_FULL);
        push_ok    = push & (~full | pop);
        ovf_set    = push & full & ~pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge sys_clock) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    assign rx_valid  = (wr_ptr_q != rd_ptr_q);
    assign rx_level  = wr_ptr_q - rd_ptr_q;
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: drives 8N1 frames and compares the stream
// port against a queue-based model of the received-byte FIFO.

module tb_uart_rx_fifo;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 2 + DIV / 2 + 9 * DIV + 1;

    logic       sysClock = 1'b0;
    logic       resetN;
    logic       uartRxd;
    logic       rxReady;
    logic       overflowClr;
    logic [7:0] rxData;
    logic       rxValid;
    logic [2:0] rxLevel;
    logic       frameErr;
    logic       overflow;

    int         assertCount = 0;
    int         failCount   = 0;
    logic [7:0] expQ [$];
    logic       expOverflow = 1'b0;
    int         firstValidCycle;
    int         ferrCount;
    int         ferrCycle;

    uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .sys_clock   (sysClock),
        .reset_n     (resetN),
        .uart_rxd    (uartRxd),
        .rx_data     (rxData),
        .rx_valid    (rxValid),
        .rx_ready    (rxReady),
        .rx_level    (rxLevel),
        .frame_err   (frameErr),
        .overflow    (overflow),
        .overflow_clr(overflowClr)
    );

    always #5 sysClock = ~sysClock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        logic [7:0] expData;
        expData = (expQ.size() != 0) ? expQ[0] : 8'h00;
        checkOutput({tag, "/valid"}, 32'(rxValid), 32'(expQ.size() != 0));
        checkOutput({tag, "/level"}, 32'(rxLevel), 32'(expQ.size()));
        checkOutput({tag, "/data"}, 32'(rxData), 32'(expData));
        checkOutput({tag, "/overflow"}, 32'(overflow), 32'(expOverflow));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge sysClock);
            #1 uartRxd = 1'b1;
        end
        @(negedge sysClock);
    endtask

    // Sends one frame; cycle c counts edges after the edge that starts the start bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int popAt, input int abortAt);
        logic [9:0] frame;
        logic [3:0] bitIdx;
        logic       prevValid;
        frame           = {stopBit, data, 1'b0};
        prevValid       = rxValid;
        firstValidCycle = -1;
        ferrCount       = 0;
        ferrCycle       = -1;
        @(posedge sysClock);
        for (int c = 0; c < 10 * DIV; c++) begin
            #1;
            if (c == abortAt) begin
                resetN  = 1'b0;
                uartRxd = 1'b1;
                rxReady = 1'b0;
                @(negedge sysClock);
                expQ.delete();
                expOverflow = 1'b0;
                checkState("midReset");
                checkOutput("midReset/frameErr", 32'(frameErr), 32'd0);
                @(posedge sysClock);
                #1 resetN = 1'b1;
                @(negedge sysClock);
                return;
            end
            bitIdx  = 4'(c / DIV);
            uartRxd = frame[bitIdx];
            rxReady = (c == popAt);
            @(negedge sysClock);
            if (rxValid && !prevValid && firstValidCycle < 0) firstValidCycle = c;
            prevValid = rxValid;
            if (frameErr) begin
                ferrCount++;
                ferrCycle = c;
            end
            if (c < 10 * DIV - 1) @(posedge sysClock);
        end
        rxReady = 1'b0;
        if (stopBit) begin
            if (popAt >= 0 && popAt <= LAT - 1 && expQ.size() > 0) void'(expQ.pop_front());
            if (expQ.size() < DEPTH) expQ.push_back(data);
            else expOverflow = 1'b1;
        end
    endtask

    task automatic drainAll();
        while (expQ.size() > 0) begin
            checkState("drain");
            rxReady = 1'b1;
            @(posedge sysClock);
            #1 rxReady = 1'b0;
            void'(expQ.pop_front());
            @(negedge sysClock);
        end
        checkState("drained");
    endtask

    initial begin
        logic [7:0] rnd;
        resetN      = 1'b0;
        uartRxd     = 1'b1;
        rxReady     = 1'b0;
        overflowClr = 1'b0;
        repeat (2) @(negedge sysClock);
        checkState("reset");
        checkOutput("reset/frameErr", 32'(frameErr), 32'd0);
        @(posedge sysClock);
        #1 resetN = 1'b1;
        idleCycles(4);

        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5, 1'b1, -1, -1);
        checkOutput("single/latency", 32'(firstValidCycle), 32'(LAT));
        checkOutput("single/frameErr", 32'(ferrCount), 32'd0);
        checkState("single");
        drainAll();

        $display("[TB] glitch");
        @(posedge sysClock);
        #1 uartRxd = 1'b0;
        repeat (4) @(posedge sysClock);
        #1 uartRxd = 1'b1;
        ferrCount = 0;
        repeat (3 * DIV) begin
            @(negedge sysClock);
            if (frameErr) ferrCount++;
        end
        checkOutput("glitch/frameErr", 32'(ferrCount), 32'd0);
        checkState("glitch");

        $display("[TB] bad stop bit");
        applyStimulus(8'h3C, 1'b0, -1, -1);
        checkOutput("badStop/ferrCount", 32'(ferrCount), 32'd1);
        checkOutput("badStop/ferrCycle", 32'(ferrCycle), 32'(LAT));
        checkState("badStop");
        idleCycles(2 * DIV);
        applyStimulus(8'h81, 1'b1, -1, -1);
        checkOutput("afterBad/frameErr", 32'(ferrCount), 32'd0);
        checkState("afterBad");
        drainAll();

        $display("[TB] overflow");
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, -1, -1);
        checkState("overflow");
        drainAll();
        @(posedge sysClock);
        #1 overflowClr = 1'b1;
        @(posedge sysClock);
        #1 overflowClr = 1'b0;
        expOverflow = 1'b0;
        @(negedge sysClock);
        checkState("overflowClr");

        $display("[TB] full with simultaneous pop");
        for (int i = 0; i < DEPTH; i++) begin
            rnd = 8'($urandom);
            applyStimulus(rnd, 1'b1, -1, -1);
        end
        applyStimulus(8'h77, 1'b1, LAT - 1, -1);
        checkState("fullPop");
        drainAll();

        $display("[TB] random frames");
        for (int i = 0; i < 8; i++) begin
            rnd = 8'($urandom);
            applyStimulus(rnd, 1'b1, -1, -1);
            checkState("random");
            if (expQ.size() == DEPTH || $urandom_range(0, 1) == 1) drainAll();
        end
        drainAll();

        $display("[TB] mid-frame reset");
        for (int i = 0; i < 2; i++) begin
            rnd = 8'($urandom);
            applyStimulus(rnd, 1'b1, -1, -1);
        end
        checkState("preReset");
        applyStimulus(8'hC3, 1'b1, -1, 4 * DIV + DIV / 2);
        idleCycles(2 * DIV);
        checkState("postReset");
        applyStimulus(8'h5A, 1'b1, -1, -1);
        checkOutput("postReset/latency", 32'(firstValidCycle), 32'(LAT));
        checkState("postReset5A");
        drainAll();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
